// File: rtl/tlmon_pkg.sv
// Shared types and lamp decode helpers for the traffic light monitor.
// Optional dwell timeout is enabled by defining TLMON_TIMEOUT_EN.
package tlmon_pkg;

  typedef enum logic [1:0] {
    RED       = 2'd0,
    RED_AMBER = 2'd1,
    GREEN     = 2'd2,
    AMBER     = 2'd3
  } phase_t;

  typedef enum logic {
    UNSYNCED = 1'b0,
    TRACKING = 1'b1
  } trk_t;

  localparam logic [2:0] LAMP_RED       = 3'b100;
  localparam logic [2:0] LAMP_RED_AMBER = 3'b110;
  localparam logic [2:0] LAMP_GREEN     = 3'b001;
  localparam logic [2:0] LAMP_AMBER     = 3'b010;

  typedef struct packed {
    logic   legal;
    phase_t phase;
  } lamp_dec_t;

  function automatic lamp_dec_t lamp_to_phase(
    input logic [2:0] lamp
  );
    lamp_dec_t d;
    d.legal = 1'b1;
    d.phase = RED;
    unique case (1'b1)
      lamp == LAMP_RED:       d.phase = RED;
      lamp == LAMP_RED_AMBER: d.phase = RED_AMBER;
      lamp == LAMP_GREEN:     d.phase = GREEN;
      lamp == LAMP_AMBER:     d.phase = AMBER;
      default:                d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // The sequence is a 4-cycle ring in enum order.
  function automatic logic legal_next(
    input phase_t cur,
    input phase_t nxt
  );
    logic [1:0] succ;
    succ = cur + 2'd1;
    return (nxt == cur) || (nxt == phase_t'(succ));
  endfunction

endpackage

// File: rtl/traffic_light_monitor_tracker.sv
// Per-light sequence tracker: phase register, sync FSM, error pulses.
// Dwell counter and timeout pulse exist only with TLMON_TIMEOUT_EN.
module tl_seq_tracker
  import tlmon_pkg::*;
#(
  parameter int MAX_DWELL = 8,
  parameter int DWELL_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic [2:0] lamp,
  output phase_t     phase,
  output logic       code_err,
  output logic       seq_err,
  output logic       amber_red,
  output logic       timeout
);

  if (DWELL_W < $clog2(MAX_DWELL + 1)) begin : g_bad_dwell_w
    $error("DWELL_W too narrow for MAX_DWELL");
  end

  trk_t      state_q, state_d;
  phase_t    phase_q, phase_d;
  lamp_dec_t dec;

  assign dec   = lamp_to_phase(lamp);
  assign phase = phase_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    code_err  = 1'b0;
    seq_err   = 1'b0;
    amber_red = 1'b0;
    if (sample_en) begin
      if (!dec.legal) begin
        code_err = 1'b1;
        state_d  = UNSYNCED;
      end else begin
        state_d = TRACKING;
        phase_d = dec.phase;
        if (state_q == TRACKING) begin
          seq_err   = !legal_next(phase_q, dec.phase);
          amber_red = (phase_q == AMBER) && (dec.phase == RED);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNSYNCED;
      phase_q <= RED;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

`ifdef TLMON_TIMEOUT_EN
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MAX_DWELL);

  logic [DWELL_W-1:0] dwell_q, dwell_d;

  // A first code after sync loss starts a fresh dwell.
  always_comb begin
    dwell_d = dwell_q;
    timeout = 1'b0;
    if (sample_en) begin
      if (!dec.legal || state_q != TRACKING ||
          dec.phase != phase_q) begin
        dwell_d = '0;
      end else begin
        if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 1'b1;
        timeout = (dwell_d == DWELL_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dwell_q <= '0;
    else        dwell_q <= dwell_d;
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/traffic_light_monitor.sv
// Lamp bus monitor top: two trackers, conflict check, sticky flags.
// Build with TLMON_TIMEOUT_EN to enable the dwell timeout flag.
module traffic_light_monitor
  import tlmon_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_DWELL = 8,
  parameter int DWELL_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [2:0]       lightsA,
  input  logic [2:0]       lightsB,
  input  logic             err_clr,
  output logic [1:0]       phaseA,
  output logic [1:0]       phaseB,
  output logic             err_code,
  output logic             err_seq,
  output logic             err_conflict,
  output logic             err_timeout,
  output logic [CNT_W-1:0] rotations
);

  phase_t    ph_a, ph_b;
  logic      code_a, code_b;
  logic      seq_a, seq_b;
  logic      ar_a, ar_b;
  logic      to_a, to_b;
  lamp_dec_t dec_a, dec_b;
  logic      conflict;

  logic             code_q, seq_q, conf_q, to_q;
  logic [CNT_W-1:0] rot_q;
  logic [1:0]       rot_inc;
  logic [CNT_W:0]   rot_sum;

  tl_seq_tracker #(
    .MAX_DWELL(MAX_DWELL),
    .DWELL_W  (DWELL_W)
  ) u_trk_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_en(sample_en),
    .lamp     (lightsA),
    .phase    (ph_a),
    .code_err (code_a),
    .seq_err  (seq_a),
    .amber_red(ar_a),
    .timeout  (to_a)
  );

  tl_seq_tracker #(
    .MAX_DWELL(MAX_DWELL),
    .DWELL_W  (DWELL_W)
  ) u_trk_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_en(sample_en),
    .lamp     (lightsB),
    .phase    (ph_b),
    .code_err (code_b),
    .seq_err  (seq_b),
    .amber_red(ar_b),
    .timeout  (to_b)
  );

  assign dec_a = lamp_to_phase(lightsA);
  assign dec_b = lamp_to_phase(lightsB);

  assign conflict = sample_en &&
                    dec_a.legal && dec_b.legal &&
                    dec_a.phase != RED &&
                    dec_b.phase != RED;

  assign rot_inc = {1'b0, ar_a} + {1'b0, ar_b};
  assign rot_sum = {1'b0, rot_q} +
                   {{(CNT_W-1){1'b0}}, rot_inc};

  // A new violation outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= 1'b0;
      seq_q  <= 1'b0;
      conf_q <= 1'b0;
      to_q   <= 1'b0;
      rot_q  <= '0;
    end else begin
      code_q <= (code_q & ~err_clr) | code_a | code_b;
      seq_q  <= (seq_q  & ~err_clr) | seq_a  | seq_b;
      conf_q <= (conf_q & ~err_clr) | conflict;
      to_q   <= (to_q   & ~err_clr) | to_a   | to_b;
      if (rot_sum[CNT_W]) rot_q <= '1;
      else                rot_q <= rot_sum[CNT_W-1:0];
    end
  end

  assign phaseA       = ph_a;
  assign phaseB       = ph_b;
  assign err_code     = code_q;
  assign err_seq      = seq_q;
  assign err_conflict = conf_q;
  assign err_timeout  = to_q;
  assign rotations    = rot_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench: vector table, corner sequences, random vs model.
// Timeout expectations follow TLMON_TIMEOUT_EN.
module tb_traffic_light_monitor;

`ifdef TLMON_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif
  localparam int MAXD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_en = 1'b0;
  logic [2:0]  lights_a = 3'b100;
  logic [2:0]  lights_b = 3'b100;
  logic        err_clr = 1'b0;
  logic [1:0]  phase_a, phase_b;
  logic        e_code, e_seq, e_conf, e_to;
  logic [15:0] rot;
  logic [1:0]  s_pa, s_pb;
  logic        s_ec, s_es, s_ef, s_et;
  logic [1:0]  s_rot;

  always #5 clk = ~clk;

  traffic_light_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
    .lightsA(lights_a), .lightsB(lights_b), .err_clr(err_clr),
    .phaseA(phase_a), .phaseB(phase_b),
    .err_code(e_code), .err_seq(e_seq),
    .err_conflict(e_conf), .err_timeout(e_to),
    .rotations(rot)
  );

  traffic_light_monitor #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
    .lightsA(lights_a), .lightsB(lights_b), .err_clr(err_clr),
    .phaseA(s_pa), .phaseB(s_pb),
    .err_code(s_ec), .err_seq(s_es),
    .err_conflict(s_ef), .err_timeout(s_et),
    .rotations(s_rot)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Lamp code of each phase, indexed by phase number.
  logic [2:0] lamp_of [4] = '{3'b100, 3'b110, 3'b001, 3'b010};

  int m_sync [2];
  int m_phase [2];
  int m_dwell [2];
  bit m_ec, m_es, m_ef, m_et;
  int m_rot;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit decode(input logic [2:0] c,
                                output int ph);
    ph = 0;
    for (int k = 0; k < 4; k++)
      if (lamp_of[k] === c) begin
        ph = k;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sync[i] = 0; m_phase[i] = 0; m_dwell[i] = 0;
    end
    m_ec = 0; m_es = 0; m_ef = 0; m_et = 0; m_rot = 0;
  endtask

  task automatic model_step(input logic [2:0] a, b,
                            input logic en, clr);
    bit nc, ns, nf, nt;
    int inc;
    int ph [2];
    bit lg [2];
    logic [2:0] code [2];
    nc = 0; ns = 0; nf = 0; nt = 0; inc = 0;
    code[0] = a; code[1] = b;
    if (en) begin
      for (int i = 0; i < 2; i++) begin
        lg[i] = decode(code[i], ph[i]);
        if (!lg[i]) begin
          nc = 1; m_sync[i] = 0; m_dwell[i] = 0;
        end else begin
          if (m_sync[i] != 0) begin
            if (ph[i] != m_phase[i] &&
                ph[i] != (m_phase[i] + 1) % 4) ns = 1;
            if (m_phase[i] == 3 && ph[i] == 0) inc++;
            if (ph[i] == m_phase[i]) begin
              if (m_dwell[i] < MAXD) m_dwell[i]++;
              if (m_dwell[i] == MAXD) nt = 1;
            end else m_dwell[i] = 0;
          end else m_dwell[i] = 0;
          m_sync[i] = 1;
          m_phase[i] = ph[i];
        end
      end
      if (lg[0] && lg[1] && ph[0] != 0 && ph[1] != 0) nf = 1;
    end
    m_ec = (m_ec && !clr) || nc;
    m_es = (m_es && !clr) || ns;
    m_ef = (m_ef && !clr) || nf;
    m_et = (m_et && !clr) || (nt && TO_ON);
    m_rot += inc;
  endtask

  task automatic compare_all();
    chk("phaseA", 32'(phase_a), 32'(m_phase[0]));
    chk("phaseB", 32'(phase_b), 32'(m_phase[1]));
    chk("err_code", 32'(e_code), 32'(m_ec));
    chk("err_seq", 32'(e_seq), 32'(m_es));
    chk("err_conflict", 32'(e_conf), 32'(m_ef));
    chk("err_timeout", 32'(e_to), 32'(m_et));
    chk("rotations", 32'(rot), (m_rot > 65535) ? 65535 : m_rot);
    chk("rot_sat", 32'(s_rot), (m_rot > 3) ? 3 : m_rot);
  endtask

  task automatic step(input logic [2:0] a, b,
                      input logic en, clr);
    @(negedge clk);
    lights_a = a; lights_b = b; sample_en = en; err_clr = clr;
    @(posedge clk);
    #1;
    model_step(a, b, en, clr);
    compare_all();
  endtask

  typedef struct {
    logic [2:0] a, b;
    logic       en, clr;
    logic [1:0] pa, pb;
    logic       ec, es, ef;
    int         rot;
  } vec_t;

  function automatic vec_t mk(logic [2:0] a, b, logic clr,
                              logic [1:0] pa, pb,
                              logic es, int r);
    vec_t v;
    v.a = a; v.b = b; v.en = 1'b1; v.clr = clr;
    v.pa = pa; v.pb = pb;
    v.ec = 1'b0; v.es = es; v.ef = 1'b0; v.rot = r;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(3'b100, 3'b100, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b110, 3'b100, 0, 1, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b100, 0, 2, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b100, 0, 3, 0, 0, 0));
    tbl.push_back(mk(3'b100, 3'b100, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3'b100, 3'b110, 0, 0, 1, 0, 1));
    tbl.push_back(mk(3'b100, 3'b001, 0, 0, 2, 0, 1));
    tbl.push_back(mk(3'b100, 3'b010, 0, 0, 3, 0, 1));
    tbl.push_back(mk(3'b100, 3'b100, 0, 0, 0, 0, 2));
    tbl.push_back(mk(3'b110, 3'b100, 0, 1, 0, 0, 2));
    tbl.push_back(mk(3'b001, 3'b100, 0, 2, 0, 0, 2));
    tbl.push_back(mk(3'b100, 3'b100, 0, 0, 0, 1, 2));
    tbl.push_back(mk(3'b100, 3'b100, 1, 0, 0, 0, 2));

    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_phaseA", 32'(phase_a), 0);
    chk("reset_err_code", 32'(e_code), 0);
    chk("reset_rot", 32'(rot), 0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].a, tbl[i].b, tbl[i].en, tbl[i].clr);
      chk($sformatf("tbl%0d_pa", i), 32'(phase_a), 32'(tbl[i].pa));
      chk($sformatf("tbl%0d_pb", i), 32'(phase_b), 32'(tbl[i].pb));
      chk($sformatf("tbl%0d_ec", i), 32'(e_code), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d_es", i), 32'(e_seq), 32'(tbl[i].es));
      chk($sformatf("tbl%0d_ef", i), 32'(e_conf), 32'(tbl[i].ef));
      chk($sformatf("tbl%0d_rot", i), 32'(rot), tbl[i].rot);
    end

    // Conflict, and conflict winning over a same-cycle clear.
    step(3'b110, 3'b110, 1, 0);
    chk("conflict_set", 32'(e_conf), 1);
    chk("conflict_no_seq", 32'(e_seq), 0);
    step(3'b001, 3'b001, 1, 1);
    chk("conflict_beats_clr", 32'(e_conf), 1);
    step(3'b010, 3'b010, 1, 0);
    // Both lights finish together: +2, CNT_W=2 copy saturates.
    step(3'b100, 3'b100, 1, 0);
    chk("rot_double", 32'(rot), 4);
    chk("rot_saturated", 32'(s_rot), 3);
    step(3'b100, 3'b100, 1, 1);
    chk("clr_conflict", 32'(e_conf), 0);

    // Illegal code: phase holds, resync without seq error.
    step(3'b111, 3'b100, 1, 0);
    chk("illegal_code", 32'(e_code), 1);
    chk("illegal_phase_hold", 32'(phase_a), 0);
    step(3'b110, 3'b100, 1, 0);
    chk("resync_no_seq", 32'(e_seq), 0);
    chk("resync_phase", 32'(phase_a), 1);
    step(3'b001, 3'b100, 1, 0);

    // Asynchronous reset in GREEN, away from the clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_phaseA", 32'(phase_a), 0);
    chk("async_rst_code", 32'(e_code), 0);
    chk("async_rst_rot", 32'(rot), 0);
    compare_all();
    #1 rst_n = 1'b1;
    step(3'b010, 3'b100, 1, 0);
    chk("post_rst_no_seq", 32'(e_seq), 0);
    chk("post_rst_phase", 32'(phase_a), 3);
    step(3'b100, 3'b100, 1, 0);
    chk("post_rst_rot", 32'(rot), 1);

    // Dwell: RED held for nine more samples.
    repeat (9) step(3'b100, 3'b100, 1, 0);
    chk("dwell_timeout", 32'(e_to), 32'(TO_ON));

    // Garbage with sampling disabled is ignored.
    step(3'b111, 3'b000, 0, 0);
    step(3'b011, 3'b101, 0, 0);
    step(3'b001, 3'b001, 0, 0);
    chk("gated_code", 32'(e_code), 0);
    chk("gated_conf", 32'(e_conf), 0);
    chk("gated_phase", 32'(phase_a), 0);

    // Random traffic biased towards legal progressions.
    for (int n = 0; n < 600; n++) begin
      logic [2:0] c [2];
      for (int i = 0; i < 2; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 45)      c[i] = lamp_of[(m_phase[i] + 1) % 4];
        else if (r < 80) c[i] = lamp_of[m_phase[i]];
        else if (r < 95) c[i] = lamp_of[$urandom_range(0, 3)];
        else             c[i] = 3'($urandom_range(0, 7));
      end
      step(c[0], c[1],
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
